// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Truth tables are indexed by {a,b}, so bit 3 is the a=1,b=1 response.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int NUM_VEC = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/andgate.sv
// Plain 2-input AND cell used as the device under self-test.
// Purely combinational; no clock, no backpressure.
module andgate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/gate_hold_timer.sv
// Hold-window counter: raises last on the final cycle of each PERIOD-cycle window.
// Wraps to zero after last while enabled; clear has priority over enable.
module gate_hold_timer #(
    parameter int unsigned PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= last ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Drives all four {a,b} vectors for PERIOD cycles each and checks y against EXPECT.
// Start-to-done latency 4*PERIOD+1 cycles; start while busy is dropped, abort cancels.
module gate_selftest_ctrl
    import gate_test_pkg::*;
#(
    parameter int unsigned PERIOD = 10,
    parameter logic [3:0]  EXPECT = TT_AND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [1:0] vec_idx
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tmr_clr, tmr_en, tmr_last;

    gate_hold_timer #(.PERIOD(PERIOD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .last (tmr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // FINISH behaves like IDLE for start so a run can be relaunched during the done cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        unique case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            DRIVE: begin
                tmr_en = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b0;
                    tmr_clr = 1'b1;
                end else if (tmr_last) begin
                    if (y != EXPECT[idx_q]) begin
                        err_d[idx_q] = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        idx_d   = '0;
                        pass_d  = (err_d == 4'b0000);
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign a       = idx_q[1];
    assign b       = idx_q[0];
    assign vec_idx = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_vec = err_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench: three controllers (AND/P10, OR/P10, AND/P1), each driving a real andgate.
// Cycle n is observed 1 time unit after edge n-1; start sampled at edge 0.
module tb_gate_selftest_ctrl;
    import gate_test_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic [2:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
    logic [3:0] err_w [3];
    logic [1:0] idx_w [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        gate_selftest_ctrl #(
            .PERIOD (i == 2 ? 1 : 10),
            .EXPECT (i == 1 ? TT_OR : TT_AND)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[i]),
            .abort   (abort_v[i]),
            .y       (y_w[i]),
            .a       (a_w[i]),
            .b       (b_w[i]),
            .busy    (busy_w[i]),
            .done    (done_w[i]),
            .pass    (pass_w[i]),
            .err_vec (err_w[i]),
            .vec_idx (idx_w[i])
        );

        andgate u_gate (
            .a (a_w[i]),
            .b (b_w[i]),
            .y (y_w[i])
        );
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns in cycle 1 of the run.
    task automatic do_start(input int inst);
        next_cycle();
        start_v[inst] = 1'b1;
        next_cycle();
        start_v[inst] = 1'b0;
    endtask

    // Returns the cycle (counted from the current one as 1) in which done is seen, or -1.
    task automatic run_until_done(input int inst, input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = -1;
        for (int c = 1; c <= budget; c++) begin
            if (!seen && done_w[inst]) begin
                cyc  = c;
                seen = 1'b1;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = '0;
        abort_v = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], idx_w[i]} !== 11'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d a=%b b=%b busy=%b done=%b pass=%b err=%b idx=%b expected all zero",
                         i, a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], idx_w[i]);
            end
        end
    endtask

    task automatic test_and_run();
        logic [1:0] exp_ab;
        logic [5:0] exp_v, obs_v;
        do_start(0);
        for (int c = 1; c <= 45; c++) begin
            exp_ab = (c <= 40) ? 2'((c - 1) / 10) : 2'd0;
            exp_v  = {exp_ab, exp_ab, (c <= 40), (c == 41)};
            obs_v  = {a_w[0], b_w[0], idx_w[0], busy_w[0], done_w[0]};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL and_timeline cycle=%0d {a,b,idx,busy,done}=%b expected %b", c, obs_v, exp_v);
            end
            next_cycle();
        end
        checks++;
        if (pass_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL and_pass got=%b expected 1", pass_w[0]);
        end
        checks++;
        if (err_w[0] !== 4'b0000) begin
            failures++;
            $display("FAIL and_err_vec got=%b expected 0000", err_w[0]);
        end
    endtask

    task automatic test_or_mismatch();
        int cyc;
        do_start(1);
        run_until_done(1, 60, cyc);
        checks++;
        if (cyc != 41) begin
            failures++;
            $display("FAIL or_done_cycle got=%0d expected 41", cyc);
        end
        checks++;
        if (pass_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL or_pass got=%b expected 0", pass_w[1]);
        end
        checks++;
        if (err_w[1] !== 4'b0110) begin
            failures++;
            $display("FAIL or_err_vec got=%b expected 0110", err_w[1]);
        end
    endtask

    task automatic test_period1();
        logic [1:0] exp_ab;
        logic [3:0] exp_v, obs_v;
        do_start(2);
        for (int c = 1; c <= 10; c++) begin
            exp_ab = (c <= 4) ? 2'(c - 1) : 2'd0;
            exp_v  = {exp_ab, (c <= 4), (c == 5)};
            obs_v  = {a_w[2], b_w[2], busy_w[2], done_w[2]};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL p1_timeline cycle=%0d {a,b,busy,done}=%b expected %b", c, obs_v, exp_v);
            end
            start_v[2] = (c == 3);
            next_cycle();
        end
        start_v[2] = 1'b0;
        checks++;
        if ({pass_w[2], err_w[2]} !== 5'b1_0000) begin
            failures++;
            $display("FAIL p1_result pass=%b err=%b expected pass=1 err=0000", pass_w[2], err_w[2]);
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic [1:0] exp_v, obs_v;
        do_start(1);
        for (int c = 1; c <= 50; c++) begin
            exp_v = {(c <= 15), 1'b0};
            obs_v = {busy_w[1], done_w[1]};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL abort_timeline cycle=%0d {busy,done}=%b expected %b", c, obs_v, exp_v);
            end
            abort_v[1] = (c == 15);
            next_cycle();
        end
        abort_v[1] = 1'b0;
        checks++;
        if ({pass_w[1], err_w[1]} !== 5'b0_0000) begin
            failures++;
            $display("FAIL abort_result pass=%b err=%b expected pass=0 err=0000", pass_w[1], err_w[1]);
        end
        do_start(1);
        run_until_done(1, 60, cyc);
        checks++;
        if (cyc != 41) begin
            failures++;
            $display("FAIL abort_rerun_done got=%0d expected 41", cyc);
        end
        checks++;
        if (err_w[1] !== 4'b0110) begin
            failures++;
            $display("FAIL abort_rerun_err got=%b expected 0110", err_w[1]);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        do_start(0);
        repeat (24) next_cycle();
        checks++;
        if ({busy_w[0], a_w[0], b_w[0]} !== 3'b110) begin
            failures++;
            $display("FAIL midrun_pre {busy,a,b}=%b expected 110", {busy_w[0], a_w[0], b_w[0]});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], idx_w[0]} !== 11'd0) begin
            failures++;
            $display("FAIL midrun_async_reset a=%b b=%b busy=%b done=%b pass=%b err=%b idx=%b expected all zero",
                     a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], idx_w[0]);
        end
        #1;
        rst = 1'b0;
        run_until_done(0, 50, cyc);
        checks++;
        if (cyc != -1) begin
            failures++;
            $display("FAIL midrun_no_done got done at cycle %0d expected none", cyc);
        end
        do_start(0);
        run_until_done(0, 60, cyc);
        checks++;
        if (cyc != 41 || pass_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_rerun done_cycle=%0d pass=%b expected 41 and 1", cyc, pass_w[0]);
        end
    endtask

    task automatic test_start_abort();
        int cyc;
        next_cycle();
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        next_cycle();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL start_abort_busy got=%b expected 1", busy_w[0]);
        end
        run_until_done(0, 60, cyc);
        checks++;
        if (cyc != 41) begin
            failures++;
            $display("FAIL start_abort_done got=%0d expected 41", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_start(1);
        for (int c = 1; c <= 41; c++) begin
            if (c < 41) next_cycle();
        end
        checks++;
        if ({done_w[1], err_w[1]} !== 5'b1_0110) begin
            failures++;
            $display("FAIL b2b_done_cycle done=%b err=%b expected done=1 err=0110", done_w[1], err_w[1]);
        end
        start_v[1] = 1'b1;
        next_cycle();
        start_v[1] = 1'b0;
        checks++;
        if ({busy_w[1], done_w[1], pass_w[1], err_w[1]} !== 7'b100_0000) begin
            failures++;
            $display("FAIL b2b_restart busy=%b done=%b pass=%b err=%b expected busy=1 done=0 pass=0 err=0000",
                     busy_w[1], done_w[1], pass_w[1], err_w[1]);
        end
        run_until_done(1, 60, cyc);
        checks++;
        if (cyc != 41) begin
            failures++;
            $display("FAIL b2b_second_done got=%0d expected 41", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_and_run();
        test_or_mismatch();
        test_period1();
        test_abort();
        test_reset_midrun();
        test_start_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
